// File: rtl/bank_pkg.sv
// Shared constants and types for the bank response path.
// The credit manager's reset credit value is BANK_BUF_DEPTH from this package.
package bank_pkg;

  localparam int CHANNEL_NUM     = 3;
  localparam int CH_ID_WIDTH     = 2;
  localparam int BANK_DATA_WIDTH = 64;
  localparam int BANK_BUF_DEPTH  = 8;
  localparam int FIFO_CNT_WIDTH  = $clog2(BANK_BUF_DEPTH) + 1;

  typedef logic [FIFO_CNT_WIDTH-1:0] fifo_cnt_t;

endpackage

// File: rtl/bank_rsp_fifo.sv
// Per-channel synchronous response FIFO; a push to a full FIFO is accepted
// only when the same cycle also pops it. BUF_DEPTH must be a power of two.
module bank_rsp_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int BUF_DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic                         i_pop,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(BUF_DEPTH):0]   o_count
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign o_full    = (r_count == CW'(BUF_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  // Payload storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bank_rsp_return_arb.sv
// Per-bank read-response return scheduler: per-channel FIFOs, round-robin
// onto one registered response bus, one credit pulse per FIFO slot freed.
module bank_rsp_return_arb #(
  parameter int CHANNEL_NUM = bank_pkg::CHANNEL_NUM,
  parameter int DATA_WIDTH  = bank_pkg::BANK_DATA_WIDTH,
  parameter int BUF_DEPTH   = bank_pkg::BANK_BUF_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               bank_rsp_valid,
  input  logic [bank_pkg::CH_ID_WIDTH-1:0]   bank_rsp_ch_id,
  input  logic [DATA_WIDTH-1:0]              bank_rsp_data,
  output logic                               rsp_valid,
  output logic [bank_pkg::CH_ID_WIDTH-1:0]   rsp_ch_id,
  output logic [DATA_WIDTH-1:0]              rsp_data,
  input  logic                               rsp_ready,
  output logic [CHANNEL_NUM-1:0]             channels_credit_release,
  output logic                               err_overflow
);

  import bank_pkg::*;

  localparam int IDW = CH_ID_WIDTH;
  localparam int CW  = $clog2(BUF_DEPTH) + 1;

  // Handshake: a response transfers on a cycle where rsp_valid & rsp_ready;
  // while rsp_valid & ~rsp_ready the held id/data stay stable.
  logic                  r_rsp_valid;
  logic [IDW-1:0]        r_rsp_ch_id;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [IDW-1:0]        r_rr_ptr;
  logic [CHANNEL_NUM-1:0] r_credit;
  logic                  r_err;

  logic [CHANNEL_NUM-1:0] w_push;
  logic [CHANNEL_NUM-1:0] w_pop;
  logic [CHANNEL_NUM-1:0] w_full;
  logic [CHANNEL_NUM-1:0] w_empty;
  logic [DATA_WIDTH-1:0]  w_head  [CHANNEL_NUM];
  logic [CW-1:0]          w_count [CHANNEL_NUM];
  logic                   w_unused_cnt;
  logic                   w_load_en;
  logic                   w_do_load;
  logic                   w_grant_valid;
  logic [IDW-1:0]         w_grant_ch;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic                   w_bad_id;
  logic                   w_ovf;

  genvar g;
  generate
    for (g = 0; g < CHANNEL_NUM; g++) begin : g_ch
      assign w_push[g] = bank_rsp_valid & (bank_rsp_ch_id == IDW'(g));
      assign w_pop[g]  = w_do_load & (w_grant_ch == IDW'(g));

      bank_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push[g]),
        .i_data  (bank_rsp_data),
        .i_pop   (w_pop[g]),
        .o_data  (w_head[g]),
        .o_full  (w_full[g]),
        .o_empty (w_empty[g]),
        .o_count (w_count[g])
      );
    end
  endgenerate

  // Occupancy is observable for debug only; flow control uses full/empty.
  always_comb begin
    w_unused_cnt = 1'b0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      w_unused_cnt = w_unused_cnt ^ (^w_count[i]);
    end
  end

  assign w_load_en = ~r_rsp_valid | rsp_ready;
  assign w_do_load = w_load_en & w_grant_valid;

  // Search starts one past the last grant so every non-empty channel is served in turn.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_ch    = '0;
    for (int k = 1; k <= CHANNEL_NUM; k++) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % CHANNEL_NUM;
      if (!w_grant_valid && !w_empty[idx]) begin
        w_grant_valid = 1'b1;
        w_grant_ch    = IDW'(idx);
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (w_pop[i]) begin
        w_sel_data = w_head[i];
      end
    end
  end

  assign w_bad_id = bank_rsp_valid & ({1'b0, bank_rsp_ch_id} >= (IDW+1)'(CHANNEL_NUM));
  assign w_ovf    = w_bad_id | (|(w_push & w_full & ~w_pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_ch_id <= '0;
      r_rsp_data  <= '0;
      r_rr_ptr    <= IDW'(CHANNEL_NUM - 1);
      r_credit    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_credit <= w_pop;
      if (w_ovf) begin
        r_err <= 1'b1;
      end
      if (w_load_en) begin
        r_rsp_valid <= w_grant_valid;
        if (w_grant_valid) begin
          r_rsp_ch_id <= w_grant_ch;
          r_rsp_data  <= w_sel_data;
          r_rr_ptr    <= w_grant_ch;
        end
      end
    end
  end

  assign rsp_valid               = r_rsp_valid;
  assign rsp_ch_id               = r_rsp_ch_id;
  assign rsp_data                = r_rsp_data;
  assign channels_credit_release = r_credit;
  assign err_overflow            = r_err;

endmodule

// File: tb/tb_bank_rsp_return_arb.sv
// Bench for bank_rsp_return_arb: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_bank_rsp_return_arb;

  localparam int N     = 3;
  localparam int DW    = 64;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          bank_rsp_valid;
  logic [1:0]    bank_rsp_ch_id;
  logic [DW-1:0] bank_rsp_data;
  logic          rsp_valid;
  logic [1:0]    rsp_ch_id;
  logic [DW-1:0] rsp_data;
  logic          rsp_ready;
  logic [N-1:0]  channels_credit_release;
  logic          err_overflow;

  always #5 clk = ~clk;

  bank_rsp_return_arb #(
    .CHANNEL_NUM (N),
    .DATA_WIDTH  (DW),
    .BUF_DEPTH   (DEPTH)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .bank_rsp_valid          (bank_rsp_valid),
    .bank_rsp_ch_id          (bank_rsp_ch_id),
    .bank_rsp_data           (bank_rsp_data),
    .rsp_valid               (rsp_valid),
    .rsp_ch_id               (rsp_ch_id),
    .rsp_data                (rsp_data),
    .rsp_ready               (rsp_ready),
    .channels_credit_release (channels_credit_release),
    .err_overflow            (err_overflow)
  );

  // Reference model: one queue per channel plus the visible output state.
  logic [DW-1:0] mq [N][$];
  logic          m_valid;
  int            m_ch;
  logic [DW-1:0] m_data;
  int            m_ptr;
  logic [N-1:0]  m_credit;
  logic          m_err;

  int n_vec = 0;
  int n_err = 0;
  int cred_cnt [N];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) mq[c].delete();
    m_valid  = 1'b0;
    m_ch     = 0;
    m_data   = '0;
    m_ptr    = N - 1;
    m_credit = '0;
    m_err    = 1'b0;
  endtask

  // One clock of the specified behaviour, using the pre-edge state.
  task automatic model_clock(input logic v, input logic [1:0] id, input logic [DW-1:0] d,
                             input logic rdy);
    int gnt;
    gnt = -1;
    if (!m_valid || rdy) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (gnt < 0 && mq[c].size() > 0) gnt = c;
      end
      if (gnt >= 0) begin
        m_data  = mq[gnt].pop_front();
        m_valid = 1'b1;
        m_ch    = gnt;
        m_ptr   = gnt;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_credit = '0;
    if (gnt >= 0) m_credit[gnt] = 1'b1;
    if (v) begin
      if (int'(id) >= N) m_err = 1'b1;
      else if (mq[id].size() >= DEPTH) m_err = 1'b1;
      else mq[id].push_back(d);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rsp_valid"}, DW'(rsp_valid), DW'(m_valid));
    check({tag, ".rsp_ch_id"}, DW'(rsp_ch_id), DW'(m_ch));
    check({tag, ".rsp_data"},  rsp_data, m_data);
    check({tag, ".credit"},    DW'(channels_credit_release), DW'(m_credit));
    check({tag, ".err"},       DW'(err_overflow), DW'(m_err));
  endtask

  task automatic step(input string tag, input logic v, input logic [1:0] id,
                      input logic [DW-1:0] d, input logic rdy);
    bank_rsp_valid = v;
    bank_rsp_ch_id = id;
    bank_rsp_data  = d;
    rsp_ready      = rdy;
    @(posedge clk);
    model_clock(v, id, d, rdy);
    #1;
    check_all(tag);
    for (int c = 0; c < N; c++) if (channels_credit_release[c]) cred_cnt[c]++;
  endtask

  task automatic idle(input string tag, input int cycles, input logic rdy);
    for (int i = 0; i < cycles; i++) step(tag, 1'b0, 2'd0, '0, rdy);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bank_rsp_valid = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bank_rsp_valid = 1'b0;
    bank_rsp_ch_id = '0;
    bank_rsp_data  = '0;
    rsp_ready      = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Single response: visible two cycles after the push, credit alongside.
    step("single.t0", 1'b1, 2'd1, 64'hA5, 1'b1);
    step("single.t1", 1'b0, 2'd0, '0, 1'b1);
    check("single.valid_t2", DW'(rsp_valid), DW'(1'b1));
    check("single.data_t2",  rsp_data, 64'hA5);
    check("single.credit_t2", DW'(channels_credit_release), DW'(3'b010));
    idle("single.drain", 3, 1'b1);

    // Fairness: 4 entries per channel, then drain with ready held high.
    for (int c = 0; c < N; c++) cred_cnt[c] = 0;
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < N; c++)
        step("fair.load", 1'b1, 2'(c), {32'hF000_0000 + 32'(c), 32'(i)}, 1'b0);
    idle("fair.drain", 14, 1'b1);
    for (int c = 0; c < N; c++) check($sformatf("fair.credits_ch%0d", c), DW'(cred_cnt[c]), DW'(4));

    // Backpressure: output held for 5 cycles, then released.
    for (int i = 0; i < 3; i++) step("bp.load", 1'b1, 2'd0, 64'hB0 + 64'(i), 1'b0);
    idle("bp.hold", 5, 1'b0);
    idle("bp.release", 5, 1'b1);

    // Full boundary on ch2.
    for (int i = 0; i < 9; i++) step("full.push", 1'b1, 2'd2, 64'hC0 + 64'(i), 1'b0);
    check("full.no_err_at_9", DW'(err_overflow), DW'(1'b0));
    step("full.push10", 1'b1, 2'd2, 64'hC9, 1'b0);
    check("full.err_at_10", DW'(err_overflow), DW'(1'b1));
    idle("full.drain", 12, 1'b1);
    check("full.err_sticky", DW'(err_overflow), DW'(1'b1));
    do_reset("full.rst");

    // Push plus pop on a full ch0 FIFO.
    for (int i = 0; i < 9; i++) step("pp.fill", 1'b1, 2'd0, 64'hD0 + 64'(i), 1'b0);
    step("pp.pushpop", 1'b1, 2'd0, 64'hDD, 1'b1);
    check("pp.no_err", DW'(err_overflow), DW'(1'b0));
    idle("pp.drain", 12, 1'b1);

    // Random traffic, keeping within the credit limit.
    for (int i = 0; i < 400; i++) begin
      logic          v;
      logic [1:0]    id;
      logic [DW-1:0] d;
      v  = 1'($urandom_range(0, 1));
      id = 2'($urandom_range(0, N - 1));
      d  = {$urandom, $urandom};
      if (mq[id].size() >= DEPTH) v = 1'b0;
      step("rand", v, id, d, 1'($urandom_range(0, 3) != 0));
    end
    idle("rand.drain", 30, 1'b1);

    // Bad channel id, then reset with 5 entries buffered.
    step("badid", 1'b1, 2'd3, 64'hEE, 1'b1);
    check("badid.err", DW'(err_overflow), DW'(1'b1));
    idle("badid.idle", 2, 1'b1);
    for (int i = 0; i < 5; i++) step("rst.load", 1'b1, 2'(i % N), 64'hE0 + 64'(i), 1'b0);
    do_reset("midrst");
    idle("post_rst", 4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bank_rsp_return_arb.md
# bank_rsp_return_arb

Per-bank read-response return scheduler. Buffers read data coming back from the bank array in one FIFO per channel, shares the single response bus to the channel interconnect between channels by round-robin, and returns one credit per drained entry to the bank issue credit manager via `channels_credit_release`. The credit loop guarantees that the bank never returns more than `BUF_DEPTH` outstanding reads per channel, so the bank side has no backpressure.

## Interface
- `CHANNEL_NUM`, 3, number of requesting channels (channel id width is fixed at 2).
- `DATA_WIDTH`, 64, response payload width.
- `BUF_DEPTH`, 8, entries per channel FIFO; equals the per-channel credit reset value in the credit manager.

- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `bank_rsp_valid`  in  1  bank read response valid this cycle
- `bank_rsp_ch_id`  in  2  owning channel of the response
- `bank_rsp_data`  in  DATA_WIDTH  response payload
- `rsp_valid`  out  1  output register holds a response
- `rsp_ch_id`  out  2  channel of the held response
- `rsp_data`  out  DATA_WIDTH  held payload
- `rsp_ready`  in  1  interconnect accepts the response this cycle
- `channels_credit_release`  out  CHANNEL_NUM  one-cycle credit-return pulse per channel
- `err_overflow`  out  1  sticky; push to a full FIFO or `ch_id >= CHANNEL_NUM`

## Operation
- Push: when `bank_rsp_valid` is high, `bank_rsp_data` is written to FIFO[`bank_rsp_ch_id`].
  - If the FIFO is full (count == `BUF_DEPTH`) and is not popped in the same cycle, the write is dropped and `err_overflow` is set.
  - A push to a full FIFO that is popped in the same cycle is legal; the count does not change.
  - A `ch_id` >= `CHANNEL_NUM` is dropped and sets `err_overflow`.
- Output register `{rsp_valid, rsp_ch_id, rsp_data}` loads when it is empty or being drained this cycle (`rsp_valid & rsp_ready`). This gives full throughput: one response per cycle.
- Arbitration: round-robin over non-empty FIFOs.
  - The search starts at `rr_ptr_Q + 1` (mod `CHANNEL_NUM`).
  - On a load, the granted channel's FIFO is popped and `rr_ptr_Q` is updated to the granted channel.
  - `rr_ptr_Q` resets to `CHANNEL_NUM-1`, so channel 0 wins first.
- Credit return: a FIFO pop sets `channels_credit_release[ch]` in the next cycle for exactly one cycle. Credit is tied to the FIFO slot being freed, not to the output handshake. At most one bit is set per cycle.
- Output hold: while `rsp_valid & ~rsp_ready`, `rsp_ch_id` and `rsp_data` are stable and no FIFO is popped.
- FIFO counters are `$clog2(BUF_DEPTH)+1` bits wide. Read and write pointers wrap modulo `BUF_DEPTH`, and `BUF_DEPTH` must be a power of two.
- `err_overflow` clears only on reset.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_ch_id`=0, `rsp_data`=0
  - `channels_credit_release`=0, `err_overflow`=0
  - all FIFO counts 0, `rr_ptr_Q`=`CHANNEL_NUM-1`
- Latency:
  - `bank_rsp_valid` in cycle t: the FIFO entry is visible at t+1; the earliest `rsp_valid` is at t+2. There is no bypass path.
  - Pop in cycle t: `channels_credit_release` pulses in cycle t+1.
- Reset mid-operation: all buffered data is discarded and no credit pulses are emitted. The credit manager is reset by the same `rst`, so its counters return to `BUF_DEPTH`.
- Simultaneous push and pop on the same FIFO in the same cycle: both take effect, and the count is unchanged.

## Structure
- Shared package `bank_pkg`: `CHANNEL_NUM`, `BANK_BUF_DEPTH`, `CH_ID_WIDTH`=2, and a typedef for FIFO count width. The credit manager's reset credit value uses `BANK_BUF_DEPTH` from this package.
- Sub-module `bank_rsp_fifo`: a synchronous FIFO parameterized on `DATA_WIDTH`/`BUF_DEPTH`, with push/pop, full/empty and count outputs. The top instantiates it `CHANNEL_NUM` times in a generate loop. The round-robin picker, output register and credit-pulse register live in the top.

## Test plan
- Single response: push ch1 data 0xA5 at t0 with `rsp_ready`=1 -> `rsp_valid`=1, `rsp_ch_id`=1, `rsp_data`=0xA5 at t0+2; `channels_credit_release`=3'b010 at t0+2; no other pulses.
- Fairness: preload 4 entries in each of ch0, ch1, ch2, then hold `rsp_ready`=1 -> grant order 0,1,2,0,1,2,… with 12 consecutive valid cycles and 12 credit pulses, 4 per channel.
- Backpressure: ch0 holds 3 entries, `rsp_ready`=0 for 5 cycles -> `rsp_data` is stable, and exactly one pop/credit occurs (for the initial load); the remaining 2 pops resume when `rsp_ready`=1.
- Full boundary: push 8 to ch2 with `rsp_ready`=0 -> 1 entry in the output register plus 7 in the FIFO, no error. Then push 2 more -> the FIFO reaches count 8; the 10th push is dropped and `err_overflow`=1. `err_overflow` stays 1 until `rst`.
- Push+pop on full: ch0 FIFO count 8 and a pop plus push in the same cycle -> count stays 8, no error, and the pushed data appears in order.
- Bad id and reset: a push with `ch_id`=3 sets `err_overflow` and writes nothing. Asserting `rst` with 5 entries buffered -> all outputs are 0 the next cycle, with no credit pulses.
